// File: rtl/instr_decode.sv
// RV32I decode stage with ID/EX pipeline register and 32x32 register file.
// Optional macro ID_ILLEGAL_DETECT_EN adds illegal_ex and stricter funct checks.
module instr_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_if,
    input  logic [31:0] instr_if,
    input  logic [31:0] instr_addr_if,
    output logic        instr_ready_id,
    input  logic        flush,
    input  logic        reg_wen,
    input  logic [4:0]  reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        ready_ex,
    output logic        valid_ex,
    output logic [31:0] instr_id_ex,
    output logic [31:0] instr_addr_ex,
    output logic [31:0] operand1_ex,
    output logic [31:0] operand2_ex,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic        illegal_ex,
`endif
    output logic        reg_wen_ex
);

    typedef enum logic [6:0] {
        OPC_LUI   = 7'b0110111,
        OPC_AUIPC = 7'b0010111,
        OPC_OP_I  = 7'b0010011,
        OPC_OP_R  = 7'b0110011
    } opcode_e;

    logic [31:0] regs [32];
    logic        retire;
    logic        accept;
    logic        commit;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op1_id;
    logic [31:0] op2_id;
    logic        supported_id;
    logic        illegal_id;
    logic        reg_wen_id;

    assign retire         = valid_ex && ready_ex;
    assign instr_ready_id = (!valid_ex || ready_ex) && !flush;
    assign accept         = instr_valid_if && instr_ready_id;
    assign commit         = reg_wen && retire && (reg_waddr != 5'd0);

    assign rs1_addr = instr_if[19:15];
    assign rs2_addr = instr_if[24:20];

    // x0 is hard-wired, so it must never see the bypassed writeback value.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (WB_BYPASS && commit && (reg_waddr == rs1_addr)) rs1_data = reg_wdata;
        if (WB_BYPASS && commit && (reg_waddr == rs2_addr)) rs2_data = reg_wdata;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        op1_id       = '0;
        op2_id       = '0;
        supported_id = 1'b1;
        case (instr_if[6:0])
            OPC_LUI: begin
                op2_id = {instr_if[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                op1_id = instr_addr_if;
                op2_id = {instr_if[31:12], 12'b0};
            end
            OPC_OP_I: begin
                op1_id = rs1_data;
                op2_id = {{20{instr_if[31]}}, instr_if[31:20]};
            end
            OPC_OP_R: begin
                op1_id = rs1_data;
                op2_id = rs2_data;
            end
            default: supported_id = 1'b0;
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    logic [6:0] funct7;
    logic [2:0] funct3;
    assign funct7 = instr_if[31:25];
    assign funct3 = instr_if[14:12];

    always_comb begin
        illegal_id = !supported_id;
        if (instr_if[6:0] == OPC_OP_R) begin
            if (funct7 == 7'h20)
                illegal_id = (funct3 != 3'b000) && (funct3 != 3'b101);
            else
                illegal_id = (funct7 != 7'h00);
        end else if (instr_if[6:0] == OPC_OP_I) begin
            if (funct3 == 3'b001)
                illegal_id = (funct7 != 7'h00);
            else if (funct3 == 3'b101)
                illegal_id = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
    end
`else
    assign illegal_id = 1'b0;
`endif

    assign reg_wen_id = supported_id && !illegal_id && (instr_if[11:7] != 5'd0);

    // NOTE: the register file is reset explicitly because cleared registers are architecturally visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[reg_waddr] <= reg_wdata;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex      <= 1'b0;
            instr_id_ex   <= NOP_INSTR;
            instr_addr_ex <= '0;
            operand1_ex   <= '0;
            operand2_ex   <= '0;
            reg_wen_ex    <= 1'b0;
`ifdef ID_ILLEGAL_DETECT_EN
            illegal_ex    <= 1'b0;
`endif
        end else if (flush) begin
            valid_ex      <= 1'b0;
            instr_id_ex   <= NOP_INSTR;
            operand1_ex   <= '0;
            operand2_ex   <= '0;
            reg_wen_ex    <= 1'b0;
`ifdef ID_ILLEGAL_DETECT_EN
            illegal_ex    <= 1'b0;
`endif
        end else if (accept) begin
            valid_ex      <= 1'b1;
            instr_id_ex   <= instr_if;
            instr_addr_ex <= instr_addr_if;
            operand1_ex   <= op1_id;
            operand2_ex   <= op2_id;
            reg_wen_ex    <= reg_wen_id;
`ifdef ID_ILLEGAL_DETECT_EN
            illegal_ex    <= illegal_id;
`endif
        end else if (retire) begin
            valid_ex      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: vector table for the issue stream, then
// hand-written stall, flush, drain and mid-stall reset sequences.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_if;
    logic [31:0] instr_if;
    logic [31:0] instr_addr_if;
    logic        instr_ready_id;
    logic        flush;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        ready_ex;
    logic        valid_ex;
    logic [31:0] instr_id_ex;
    logic [31:0] instr_addr_ex;
    logic [31:0] operand1_ex;
    logic [31:0] operand2_ex;
    logic        reg_wen_ex;
`ifdef ID_ILLEGAL_DETECT_EN
    logic        illegal_ex;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] Y_IN = 32'h0070_0613;  // ADDI x12,x0,7
    localparam logic [31:0] RD_X7 = 32'h0003_85B3; // ADD x11,x7,x0

    instr_decode dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_if (instr_valid_if),
        .instr_if       (instr_if),
        .instr_addr_if  (instr_addr_if),
        .instr_ready_id (instr_ready_id),
        .flush          (flush),
        .reg_wen        (reg_wen),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .ready_ex       (ready_ex),
        .valid_ex       (valid_ex),
        .instr_id_ex    (instr_id_ex),
        .instr_addr_ex  (instr_addr_ex),
        .operand1_ex    (operand1_ex),
        .operand2_ex    (operand2_ex),
`ifdef ID_ILLEGAL_DETECT_EN
        .illegal_ex     (illegal_ex),
`endif
        .reg_wen_ex     (reg_wen_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        wen;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_stage(input string tag, input logic v, input logic [31:0] ins,
                               input logic [31:0] o1, input logic [31:0] o2, input logic w);
        check({tag, "_valid"}, {31'd0, valid_ex}, {31'd0, v});
        check({tag, "_instr"}, instr_id_ex, ins);
        check({tag, "_op1"}, operand1_ex, o1);
        check({tag, "_op2"}, operand2_ex, o2);
        check({tag, "_wen"}, {31'd0, reg_wen_ex}, {31'd0, w});
    endtask

    initial begin
        // Each retiring instruction's writeback is presented alongside the next issue.
        vecs[0]  = '{32'h0050_0093, 32'h000, 1'b0, 5'd0, 32'h0,          32'h0,          32'h5,          1'b1};
        vecs[1]  = '{32'h0020_81B3, 32'h004, 1'b1, 5'd1, 32'h5,          32'h5,          32'h0,          1'b1};
        vecs[2]  = '{32'hFFD0_0113, 32'h008, 1'b1, 5'd3, 32'h5,          32'h0,          32'hFFFF_FFFD,  1'b1};
        vecs[3]  = '{32'h0030_8233, 32'h00C, 1'b1, 5'd2, 32'hFFFF_FFFD,  32'h5,          32'h5,          1'b1};
        vecs[4]  = '{32'h0000_1317, 32'h100, 1'b1, 5'd4, 32'hA,          32'h100,        32'h1000,       1'b1};
        vecs[5]  = '{32'h1234_52B7, 32'h104, 1'b1, 5'd6, 32'h1100,       32'h0,          32'h1234_5000,  1'b1};
        vecs[6]  = '{32'h4061_03B3, 32'h108, 1'b1, 5'd5, 32'h1234_5000,  32'hFFFF_FFFD,  32'h1100,       1'b1};
        vecs[7]  = '{32'h0050_0433, 32'h10C, 1'b1, 5'd0, 32'hDEAD_BEEF,  32'h0,          32'h1234_5000,  1'b1};
        vecs[8]  = '{32'h0010_0013, 32'h110, 1'b0, 5'd0, 32'h0,          32'h0,          32'h1,          1'b0};
        vecs[9]  = '{32'h0011_2023, 32'h114, 1'b0, 5'd0, 32'h0,          32'h0,          32'h0,          1'b0};
        vecs[10] = '{32'h4041_5513, 32'h118, 1'b0, 5'd0, 32'h0,          32'hFFFF_FFFD,  32'h404,        1'b1};

        rst_n = 1'b0; instr_valid_if = 1'b0; instr_if = '0; instr_addr_if = '0;
        flush = 1'b0; reg_wen = 1'b0; reg_waddr = '0; reg_wdata = '0; ready_ex = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_stage("reset", 1'b0, NOP, 32'h0, 32'h0, 1'b0);
        check("reset_addr", instr_addr_ex, 32'h0);
        check("reset_ready", {31'd0, instr_ready_id}, 32'h1);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            instr_valid_if = 1'b1; ready_ex = 1'b1;
            instr_if = vecs[i].instr; instr_addr_if = vecs[i].pc;
            reg_wen = vecs[i].wb_en; reg_waddr = vecs[i].wb_addr; reg_wdata = vecs[i].wb_data;
            @(posedge clk); #1;
            check_stage($sformatf("v%0d", i), 1'b1, vecs[i].instr, vecs[i].op1, vecs[i].op2, vecs[i].wen);
            check($sformatf("v%0d_pc", i), instr_addr_ex, vecs[i].pc);
        end

        // Stall: ID/EX held while execute is busy, new instruction waits.
        @(negedge clk);
        ready_ex = 1'b0; reg_wen = 1'b0; instr_if = Y_IN; instr_addr_if = 32'h11C;
        #1 check("stall_ready", {31'd0, instr_ready_id}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_stage($sformatf("stall%0d", c), 1'b1, vecs[10].instr, 32'hFFFF_FFFD, 32'h404, 1'b1);
            check($sformatf("stall%0d_ready", c), {31'd0, instr_ready_id}, 32'h0);
        end
        @(negedge clk);
        ready_ex = 1'b1;
        #1 check("unstall_ready", {31'd0, instr_ready_id}, 32'h1);
        @(posedge clk); #1;
        check_stage("unstall", 1'b1, Y_IN, 32'h0, 32'h7, 1'b1);

        // Flush while the live instruction retires with a writeback to x7.
        @(negedge clk);
        flush = 1'b1; reg_wen = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'h55;
        #1 check("flush_ready", {31'd0, instr_ready_id}, 32'h0);
        @(posedge clk); #1;
        check_stage("flush", 1'b0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        flush = 1'b0; reg_wen = 1'b0; instr_if = RD_X7; instr_addr_if = 32'h200;
        @(posedge clk); #1;
        check_stage("read_x7", 1'b1, RD_X7, 32'h55, 32'h0, 1'b1);

        // Retire with nothing to accept: valid drops, data holds.
        @(negedge clk);
        instr_valid_if = 1'b0;
        @(posedge clk); #1;
        check_stage("drain", 1'b0, RD_X7, 32'h55, 32'h0, 1'b1);

        // Asynchronous reset during a stall drops the held instruction and clears x7.
        @(negedge clk);
        instr_valid_if = 1'b1; instr_if = Y_IN; ready_ex = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", {31'd0, valid_ex}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_stage("midrst", 1'b0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; ready_ex = 1'b1; instr_if = RD_X7; instr_addr_if = 32'h300;
        @(posedge clk); #1;
        check_stage("post_rst_x7", 1'b1, RD_X7, 32'h0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
